// File: rtl/sum_stream_accumulator_if.sv
// Handshake bundle between the adder sum stream, the accumulator and the
// consumer of the frame total.
interface sum_stream_accumulator_if #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 40,
  parameter int LEN_W  = 8
);
  logic              start;
  logic [LEN_W-1:0]  len;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [ACC_W-1:0]  out_data;
  logic [LEN_W-1:0]  out_count;
  logic              overflow;
  logic              out_ready;
  logic              busy;

  modport slave (
    input  start, len, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_count, overflow, busy
  );

  modport master (
    output start, len, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_count, overflow, busy
  );
endinterface

// File: rtl/sum_stream_accumulator.sv
// Accumulates a programmed number of DATA_W-bit sum words into an ACC_W-bit
// total and hands it downstream over valid/ready.
module sum_stream_accumulator #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 40,
  parameter int LEN_W  = 8
) (
  input logic                      clk,
  input logic                      rst,
  sum_stream_accumulator_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t            state, state_nxt;
  logic [ACC_W-1:0]  acc;
  logic [LEN_W-1:0]  remaining;
  logic [LEN_W-1:0]  count;
  logic              ovf;
  logic [ACC_W:0]    sum;
  logic              in_hs, out_hs, frame_start;

  // in_ready depends on state only, so there is no in_valid -> in_ready path
  assign bus.in_ready  = (state == ACCUM);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_data  = bus.out_valid ? acc   : '0;
  assign bus.out_count = bus.out_valid ? count : '0;
  assign bus.overflow  = bus.out_valid ? ovf   : 1'b0;

  assign in_hs       = bus.in_valid & bus.in_ready;
  assign out_hs      = bus.out_valid & bus.out_ready;
  assign frame_start = (state == IDLE) & bus.start;
  // One spare bit captures the carry out of the accumulator
  assign sum         = {1'b0, acc} + (ACC_W+1)'(bus.in_data);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start) state_nxt = (bus.len == '0) ? DONE : ACCUM;
      ACCUM:   if (in_hs && remaining == LEN_W'(1)) state_nxt = DONE;
      DONE:    if (out_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      remaining <= '0;
      count     <= '0;
      ovf       <= 1'b0;
    end else if (frame_start) begin
      acc       <= '0;
      remaining <= bus.len;
      count     <= '0;
      ovf       <= 1'b0;
    end else if (in_hs) begin
      acc       <= sum[ACC_W-1:0];
      remaining <= remaining - LEN_W'(1);
      count     <= count + LEN_W'(1);
      ovf       <= ovf | sum[ACC_W];
    end
  end

endmodule

// File: tb/tb_sum_stream_accumulator.sv
// Directed bench for sum_stream_accumulator: a table of whole frames plus
// hand-written sequences for wrap, back-pressure, reset abort and carry-out.
module tb_sum_stream_accumulator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sum_stream_accumulator_if #(.DATA_W(32), .ACC_W(40), .LEN_W(8)) a ();
  sum_stream_accumulator_if #(.DATA_W(32), .ACC_W(33), .LEN_W(8)) b ();

  sum_stream_accumulator #(.DATA_W(32), .ACC_W(40), .LEN_W(8)) dut (
    .clk(clk), .rst(rst), .bus(a)
  );

  // Narrow accumulator so a short frame can carry out of the top bit
  sum_stream_accumulator #(.DATA_W(32), .ACC_W(33), .LEN_W(8)) dut_narrow (
    .clk(clk), .rst(rst), .bus(b)
  );

  typedef struct {
    logic [7:0]       len;
    logic [3:0][31:0] w;
    int               gap;
    logic [39:0]      data;
    logic [7:0]       count;
    logic             ovf;
  } vec_t;

  int n_chk = 0;
  int n_err = 0;
  vec_t vec[6];

  function automatic vec_t mk(logic [7:0] len, logic [31:0] w0, w1, w2, w3,
                              int gap, logic [39:0] data, logic [7:0] count,
                              logic ovf);
    vec_t v;
    v.len = len; v.w = {w3, w2, w1, w0}; v.gap = gap;
    v.data = data; v.count = count; v.ovf = ovf;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(vec_t v);
    a.start = 1'b1; a.len = v.len;
    step();
    a.start = 1'b0;
    if (v.len == 0) begin
      chk("len0_in_ready", a.in_ready, 0);
    end else begin
      for (int i = 0; i < v.len; i++) begin
        if (i > 0) begin
          for (int g = 0; g < v.gap; g++) begin
            a.in_valid = 1'b0;
            step();
            chk("stall_in_ready", a.in_ready, 1);
            chk("stall_out_valid", a.out_valid, 0);
          end
        end
        a.in_valid = 1'b1; a.in_data = v.w[i];
        chk("accum_in_ready", a.in_ready, 1);
        step();
      end
      a.in_valid = 1'b0;
    end
    chk("done_out_valid", a.out_valid, 1);
    chk("done_out_data", a.out_data, v.data);
    chk("done_out_count", a.out_count, v.count);
    chk("done_overflow", a.overflow, v.ovf);
    chk("done_in_ready", a.in_ready, 0);
    chk("done_busy", a.busy, 1);
    a.out_ready = 1'b1;
    step();
    a.out_ready = 1'b0;
    chk("idle_out_valid", a.out_valid, 0);
    chk("idle_out_data", a.out_data, 0);
    chk("idle_busy", a.busy, 0);
  endtask

  initial begin
    vec_t v;
    logic [39:0] held;

    a.start = 0; a.len = 0; a.in_valid = 0; a.in_data = 0; a.out_ready = 0;
    b.start = 0; b.len = 0; b.in_valid = 0; b.in_data = 0; b.out_ready = 0;

    vec[0] = mk(8'd3, 32'h10, 32'h20, 32'h30, 32'h0, 0, 40'h60, 8'd3, 1'b0);
    vec[1] = mk(8'd2, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 5,
                40'h1_0000_0000, 8'd2, 1'b0);
    vec[2] = mk(8'd0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 40'h0, 8'd0, 1'b0);
    vec[3] = mk(8'd4, 32'h1, 32'h2, 32'h3, 32'h4, 1, 40'hA, 8'd4, 1'b0);
    vec[4] = mk(8'd1, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0, 0,
                40'hDE_ADBE_EF, 8'd1, 1'b0);
    vec[5] = mk(8'd4, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF,
                32'h1234_5678, 2, 40'h2_1234_5677, 8'd4, 1'b0);

    #2;
    chk("rst_out_valid", a.out_valid, 0);
    chk("rst_out_data", a.out_data, 0);
    chk("rst_in_ready", a.in_ready, 0);
    chk("rst_busy", a.busy, 0);
    step(); step();
    rst = 1'b0;
    step();

    for (int i = 0; i < 6; i++) run_frame(vec[i]);

    // 255 words of 0xFFFFFFFF sum to 0xFEFFFFFF01, still below 2**40: no carry
    v = mk(8'd255, 32'h0, 32'h0, 32'h0, 32'h0, 0, 40'h0, 8'd0, 1'b0);
    a.start = 1'b1; a.len = 8'd255;
    step();
    a.start = 1'b0;
    a.in_valid = 1'b1; a.in_data = 32'hFFFF_FFFF;
    repeat (254) step();
    chk("wrap_not_done_early", a.out_valid, 0);
    step();
    a.in_valid = 1'b0;
    chk("wrap_out_valid", a.out_valid, 1);
    chk("wrap_out_data", a.out_data, 40'hFE_FFFF_FF01);
    chk("wrap_out_count", a.out_count, 255);
    chk("wrap_overflow", a.overflow, 0);

    // Back-pressure: result must hold while start pulses are ignored
    held = a.out_data;
    for (int c = 0; c < 10; c++) begin
      a.start = (c == 3); a.len = 8'd7;
      step();
      chk("bp_out_valid", a.out_valid, 1);
      chk("bp_out_data", a.out_data, held);
      chk("bp_out_count", a.out_count, 255);
    end
    a.out_ready = 1'b1; a.start = 1'b1; a.len = 8'd7;
    step();
    a.out_ready = 1'b0; a.start = 1'b0;
    chk("bp_idle_busy", a.busy, 0);
    chk("bp_idle_in_ready", a.in_ready, 0);
    chk("bp_idle_out_valid", a.out_valid, 0);
    v = mk(8'd1, 32'h7, 32'h0, 32'h0, 32'h0, 0, 40'h7, 8'd1, 1'b0);
    run_frame(v);

    // Reset mid-frame: async clear, frame dropped
    a.start = 1'b1; a.len = 8'd4;
    step();
    a.start = 1'b0;
    a.in_valid = 1'b1; a.in_data = 32'h100;
    step(); step();
    a.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", a.busy, 0);
    chk("abort_in_ready", a.in_ready, 0);
    chk("abort_out_valid", a.out_valid, 0);
    chk("abort_out_data", a.out_data, 0);
    step(); step();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("abort_no_result", a.out_valid, 0);
    end
    v = mk(8'd1, 32'h5, 32'h0, 32'h0, 32'h0, 0, 40'h5, 8'd1, 1'b0);
    run_frame(v);

    // Carry out of a 33-bit total on the third word, then sticky through word 4
    b.start = 1'b1; b.len = 8'd4;
    step();
    b.start = 1'b0;
    b.in_valid = 1'b1; b.in_data = 32'hFFFF_FFFF;
    repeat (3) step();
    b.in_data = 32'h1;
    step();
    b.in_valid = 1'b0;
    chk("ovf_out_valid", b.out_valid, 1);
    chk("ovf_out_data", b.out_data, 33'h0_FFFF_FFFE);
    chk("ovf_out_count", b.out_count, 4);
    chk("ovf_overflow", b.overflow, 1);
    b.out_ready = 1'b1;
    step();
    b.out_ready = 1'b0;
    chk("ovf_gated", b.overflow, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
